// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl: modulo-N up/down counter whose state register updates
// exclusively through per-bit JK excitation. The combinational j/k/tc
// outputs describe what the coming rising edge will do to q.
module jk_count_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc
);

    // One extra bit so MODULUS == 2**WIDTH is representable and wrap compares are exact.
    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] MAX_W  = MOD_W - ONE_W;
    localparam logic [WIDTH:0] ZERO_W = '0;

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_COUNT,
        MODE_LOAD
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   q_eff;
    logic [WIDTH:0]   nxt_x;
    logic [WIDTH:0]   d_x;
    logic [WIDTH:0]   dl_x;
    logic [WIDTH-1:0] dl;
    logic [WIDTH-1:0] flip;
    logic             unused_msb;

    // Mode select by priority: load over count over hold.
    always_comb begin
        mode = MODE_HOLD;
        if (load) begin
            mode = MODE_LOAD;
        end else if (en) begin
            mode = MODE_COUNT;
        end
    end

    // Next count value; an out-of-range q is treated as the top legal value.
    always_comb begin
        q_x   = {1'b0, q_q};
        q_eff = (q_x >= MOD_W) ? MAX_W : q_x;
        nxt_x = '0;
        if (up) begin
            nxt_x = (q_eff == MAX_W) ? ZERO_W : (q_eff + ONE_W);
        end else begin
            nxt_x = (q_eff == ZERO_W) ? MAX_W : (q_eff - ONE_W);
        end
        flip = q_q ^ nxt_x[WIDTH-1:0];
    end

    // Load value clamped to the top legal count.
    always_comb begin
        d_x  = {1'b0, d};
        dl_x = (d_x < MOD_W) ? d_x : MAX_W;
        dl   = dl_x[WIDTH-1:0];
    end

    // Both MSBs are provably zero (values never exceed MAX_W < 2**WIDTH).
    assign unused_msb = nxt_x[WIDTH] | dl_x[WIDTH];

    // JK excitation for the selected mode.
    always_comb begin
        j = '0;
        k = '0;
        case (mode)
            MODE_LOAD: begin
                j = dl;
                k = ~dl;
            end
            MODE_COUNT: begin
                j = flip;
                k = flip;
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end

    // Terminal count: enabled count about to wrap in the current direction.
    always_comb begin
        tc = 1'b0;
        if (en && !load) begin
            tc = up ? ({1'b0, q_q} == MAX_W) : (q_q == '0);
        end
    end

    // JK flip-flop characteristic equation, bitwise.
    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed bench for jk_count_ctrl: default 4-bit mod-10 instance plus a
// 3-bit mod-8 instance for full-range wrap.
module tb_jk_count_ctrl;

    logic       clk;
    logic       rst;
    logic       en_a, up_a, load_a;
    logic [3:0] d_a, q_a, j_a, k_a;
    logic       tc_a;
    logic       en_b, up_b, load_b;
    logic [2:0] d_b, q_b, j_b, k_b;
    logic       tc_b;

    int total;
    int bad;

    jk_count_ctrl #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(load_a),
        .d(d_a), .q(q_a), .j(j_a), .k(k_a), .tc(tc_a)
    );

    jk_count_ctrl #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(load_b),
        .d(d_b), .q(q_b), .j(j_b), .k(k_b), .tc(tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] jk_rule(input logic [7:0] qp, input logic [7:0] jp,
                                           input logic [7:0] kp);
        return (jp & ~qp) | (~kp & qp);
    endfunction

    // One edge on instance A: check tc before the edge, then q and the JK rule after.
    task automatic step_a(input string tag, input logic [3:0] exp_q, input logic exp_tc);
        logic [7:0] pq, pj, pk;
        #1;
        chk({tag, "_tc"}, 8'(tc_a), 8'(exp_tc));
        pq = 8'(q_a); pj = 8'(j_a); pk = 8'(k_a);
        @(posedge clk);
        #1;
        chk({tag, "_q"}, 8'(q_a), 8'(exp_q));
        chk({tag, "_jk"}, 8'(q_a), jk_rule(pq, pj, pk));
        @(negedge clk);
    endtask

    task automatic step_b(input string tag, input logic [2:0] exp_q, input logic exp_tc);
        logic [7:0] pq, pj, pk;
        #1;
        chk({tag, "_tc"}, 8'(tc_b), 8'(exp_tc));
        pq = 8'(q_b); pj = 8'(j_b); pk = 8'(k_b);
        @(posedge clk);
        #1;
        chk({tag, "_q"}, 8'(q_b), 8'(exp_q));
        chk({tag, "_jk"}, 8'(q_b), jk_rule(pq, pj, pk));
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] up_seq [12];
        logic [3:0] dn_seq [4];
        logic [2:0] bu_seq [9];
        total = 0;
        bad   = 0;
        rst = 1'b1;
        en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; d_a = '0;
        en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; d_b = '0;

        // Reset: q held at 0, excitations follow q=0.
        #1;
        chk("rst_q", 8'(q_a), 8'h0);
        chk("rst_hold_j", 8'(j_a), 8'h0);
        chk("rst_hold_tc", 8'(tc_a), 8'h0);
        en_a = 1'b1; up_a = 1'b1; #1;
        chk("rst_up_j", 8'(j_a), 8'h1);
        chk("rst_up_k", 8'(k_a), 8'h1);
        chk("rst_up_tc", 8'(tc_a), 8'h0);
        up_a = 1'b0; #1;
        chk("rst_dn_j", 8'(j_a), 8'h9);
        chk("rst_dn_tc", 8'(tc_a), 8'h1);
        @(posedge clk); #1;
        chk("rst_edge_q", 8'(q_a), 8'h0);
        @(negedge clk);
        rst = 1'b0;

        // Up count over the wrap.
        up_a = 1'b1; en_a = 1'b1;
        up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 12; i++) begin
            step_a($sformatf("up%0d", i), up_seq[i], (up_seq[i] == 4'd0));
        end

        // Down count through 0 -> 9.
        up_a = 1'b0;
        dn_seq = '{4'd1, 4'd0, 4'd9, 4'd8};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                #1;
                chk("dn_q0_j", 8'(j_a), 8'h9);
                chk("dn_q0_k", 8'(k_a), 8'h9);
            end
            step_a($sformatf("dn%0d", i), dn_seq[i], (dn_seq[i] == 4'd9));
        end

        // Load beats count; oversized load clamps.
        load_a = 1'b1; d_a = 4'd6; #1;
        chk("ld6_j", 8'(j_a), 8'h6);
        chk("ld6_k", 8'(k_a), 8'h9);
        step_a("ld6", 4'd6, 1'b0);
        d_a = 4'd13; #1;
        chk("ld13_j", 8'(j_a), 8'h9);
        chk("ld13_k", 8'(k_a), 8'h6);
        step_a("ld13", 4'd9, 1'b0);
        up_a = 1'b1; d_a = 4'd4;
        step_a("ld4_at9", 4'd4, 1'b0);

        // Hold, then direction change every edge.
        load_a = 1'b0; en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d_j", i), 8'(j_a), 8'h0);
            chk($sformatf("hold%0d_k", i), 8'(k_a), 8'h0);
            step_a($sformatf("hold%0d", i), 4'd4, 1'b0);
        end
        en_a = 1'b1;
        up_a = 1'b1; step_a("dir0", 4'd5, 1'b0);
        up_a = 1'b0; step_a("dir1", 4'd4, 1'b0);
        up_a = 1'b1; step_a("dir2", 4'd5, 1'b0);
        up_a = 1'b0; step_a("dir3", 4'd4, 1'b0);

        // Asynchronous reset between edges, then release.
        load_a = 1'b1; d_a = 4'd7; en_a = 1'b0;
        step_a("ld7", 4'd7, 1'b0);
        load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_q", 8'(q_a), 8'h0);
        chk("arst_j", 8'(j_a), 8'h1);
        load_a = 1'b1; d_a = 4'd5;
        @(posedge clk); #1;
        chk("arst_edge_q", 8'(q_a), 8'h0);
        @(negedge clk);
        rst = 1'b0; load_a = 1'b0;
        step_a("arst_rel", 4'd1, 1'b0);

        // 3-bit, modulus 8: full-range wrap both ways.
        en_a = 1'b0;
        en_b = 1'b1; up_b = 1'b1;
        bu_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        for (int i = 0; i < 9; i++) begin
            if (i == 7) begin
                #1;
                chk("b_q7_j", 8'(j_b), 8'h7);
                chk("b_q7_k", 8'(k_b), 8'h7);
            end
            step_b($sformatf("bup%0d", i), bu_seq[i], (bu_seq[i] == 3'd0));
        end
        up_b = 1'b0;
        step_b("bdn0", 3'd0, 1'b0);
        step_b("bdn1", 3'd7, 1'b1);
        step_b("bdn2", 3'd6, 1'b0);
        load_b = 1'b1; d_b = 3'd7;
        step_b("bld7", 3'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_count_ctrl.md
JK_COUNT_CTRL -- requirements
Module: jk_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..8).
REQ-002 Parameter MODULUS, default 10, count modulus (2..2^WIDTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 d  input  WIDTH  load value.
REQ-009 q  output  WIDTH  registered count.
REQ-010 j  output  WIDTH  per-bit J excitation for the coming edge, combinational.
REQ-011 k  output  WIDTH  per-bit K excitation for the coming edge, combinational.
REQ-012 tc  output  1  terminal count, combinational.

Function
REQ-013 Each bit of q SHALL update only by the JK rule: q[i]+ = (j[i] & ~q[i]) | (~k[i] & q[i]).
REQ-014 The controller SHALL operate in exactly one mode per cycle, chosen by priority: LOAD (load=1), then COUNT (en=1), then HOLD.
REQ-015 HOLD: j = 0 and k = 0 on all bits, so q is unchanged.
REQ-016 LOAD: j = dl and k = ~dl, where dl = d if d < MODULUS, else dl = MODULUS-1. q equals dl after the edge.
REQ-017 COUNT: j = k = q XOR nxt, so changing bits toggle and other bits hold.
REQ-018 COUNT up: nxt = 0 if q == MODULUS-1, else q+1.
REQ-019 COUNT down: nxt = MODULUS-1 if q == 0, else q-1.
REQ-020 If q >= MODULUS (illegal state), COUNT SHALL treat q as MODULUS-1 when computing nxt in either direction. q returns to the legal range in one enabled edge.
REQ-021 tc = 1 iff en = 1, load = 0, and either (up = 1 and q == MODULUS-1) or (up = 0 and q == 0). Otherwise tc = 0.
REQ-022 j, k and tc SHALL depend only on the current q and inputs, with no added latency. q reflects a mode one edge later.
REQ-023 A change of direction SHALL take effect on the very next edge, with no dead cycle.
REQ-024 load and en both asserted: LOAD wins and no count occurs in that cycle.
REQ-025 All arithmetic SHALL be done at WIDTH+1 bits internally, so that wrap detection at MODULUS = 2^WIDTH is exact.

Reset
REQ-026 While rst = 1, q SHALL be 0 immediately, independent of clk. Inputs are ignored.
REQ-027 During reset, j, k and tc SHALL follow their combinational definitions from q = 0.
REQ-028 On rst deassertion, the first rising edge SHALL apply the mode selected at that edge.
REQ-029 Asserting rst mid-count or mid-load SHALL abort the operation, with q = 0 and no residual state.

Verification
REQ-030 Defaults: rst pulse, then en=1, up=1 for 12 edges -> q = 1..9, 0, 1, 2; tc=1 only while q=9.
REQ-031 Down count: en=1, up=0 from q=0 -> q = 9, 8, ...; tc=1 while q=0. Excitation check at q=0: j=k=4'b1001.
REQ-032 Load: load=1, d=6, en=1 -> q=6 next edge, j=4'b0110, k=4'b1001, no count. Then load=1, d=13 -> q=9 (clamp).
REQ-033 Hold and direction: en=0 for 3 edges with q=4 -> q stays 4, j=k=0. Then en=1 with up toggling every edge from q=4 -> q = 5, 4, 5, 4.
REQ-034 Async reset: assert rst between edges at q=7 -> q=0 before the next edge. Release rst with en=1, up=1 -> q=1 after the first edge.
REQ-035 Continuous checker on every edge: the new q equals the JK rule applied to the prior q, j, k. Repeat the scenarios with WIDTH=3, MODULUS=8 to confirm full-range wrap 7->0 and 0->7.
